// File: rtl/acc_addr_seq.sv
// acc_addr_seq: strided accumulator address generator with pass counting and a configurable output pipeline
module acc_addr_seq #(
   parameter int COUNTER_WIDTH = 32,
   parameter int MATRIX_WIDTH  = 14,
   parameter int LEN_WIDTH     = 8,
   parameter int REPS_WIDTH    = 16,
   parameter int OUT_LATENCY   = 2
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     enable,
   input  logic                     load,
   input  logic [COUNTER_WIDTH-1:0] start_val,
   input  logic [LEN_WIDTH-1:0]     length,
   input  logic [COUNTER_WIDTH-1:0] stride,
   input  logic [REPS_WIDTH-1:0]    reps,
   output logic [COUNTER_WIDTH-1:0] ctr_val,
   output logic                     ctr_valid,
   output logic                     wrap,
   output logic                     done,
   output logic                     busy
);
   localparam int SW = COUNTER_WIDTH + 3;
   typedef enum logic {IDLE, ACTIVE} state_t;
   state_t                   state_q;
   logic [COUNTER_WIDTH-1:0] addr_q, start_q, stride_q;
   logic [LEN_WIDTH-1:0]     len_q, idx_q;
   logic [REPS_WIDTH-1:0]    reps_q, pass_q;
   logic                     issue, wrap_c, done_c;
   logic [SW-1:0]            stage_d, stage_o;
   assign issue   = (state_q == ACTIVE) && enable && !load;
   assign wrap_c  = idx_q == len_q - LEN_WIDTH'(1);
   assign done_c  = wrap_c && (reps_q != '0) && (pass_q == reps_q - REPS_WIDTH'(1));
   assign stage_d = {addr_q, issue, issue && wrap_c, issue && done_c};
   assign {ctr_val, ctr_valid, wrap, done} = stage_o;
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= IDLE;
         addr_q   <= '0;
         start_q  <= '0;
         stride_q <= '0;
         len_q    <= '0;
         idx_q    <= '0;
         reps_q   <= '0;
         pass_q   <= '0;
      end else if (load) begin
         state_q  <= ACTIVE;
         addr_q   <= start_val;
         start_q  <= start_val;
         stride_q <= stride;
         len_q    <= (length == '0) ? LEN_WIDTH'(MATRIX_WIDTH) : length;
         idx_q    <= '0;
         reps_q   <= reps;
         pass_q   <= '0;
      end else if (issue) begin
         if (wrap_c) begin
            addr_q <= start_q;
            idx_q  <= '0;
            pass_q <= pass_q + REPS_WIDTH'(1);
            if (done_c) state_q <= IDLE;
         end else begin
            addr_q <= addr_q + stride_q;
            idx_q  <= idx_q + LEN_WIDTH'(1);
         end
      end
   end
   generate
      if (OUT_LATENCY == 0) begin : g_comb
         assign stage_o = stage_d;
         assign busy    = state_q == ACTIVE;
      end else begin : g_pipe
         logic [SW-1:0] pipe_q [OUT_LATENCY];
         logic          any_v;
         always_ff @(posedge clk) begin
            if (rst) begin
               for (int i = 0; i < OUT_LATENCY; i++) pipe_q[i] <= '0;
            end else begin
               pipe_q[0] <= stage_d;
               for (int i = 1; i < OUT_LATENCY; i++) pipe_q[i] <= pipe_q[i-1];
            end
         end
         always_comb begin
            any_v = 1'b0;
            for (int i = 0; i < OUT_LATENCY; i++) any_v = any_v | pipe_q[i][2];
         end
         assign stage_o = pipe_q[OUT_LATENCY-1];
         assign busy    = (state_q == ACTIVE) || any_v;
      end
   endgenerate
endmodule

// File: tb/tb_acc_addr_seq.sv
// tb_acc_addr_seq: scoreboard bench; a reference model queues each issued address with its due cycle
module tb_acc_addr_seq;
   localparam int L = 2;
   logic        clk = 1'b0, rst = 1'b1, enable = 1'b0, load = 1'b0;
   logic [31:0] start_val = '0, stride = '0;
   logic [7:0]  length = '0;
   logic [15:0] reps = '0;
   logic [31:0] ctr_val;
   logic        ctr_valid, wrap, done, busy;
   acc_addr_seq #(.OUT_LATENCY(L)) dut (
      .clk(clk), .rst(rst), .enable(enable), .load(load), .start_val(start_val),
      .length(length), .stride(stride), .reps(reps), .ctr_val(ctr_val),
      .ctr_valid(ctr_valid), .wrap(wrap), .done(done), .busy(busy)
   );
   always #5 clk = ~clk;
   typedef struct {logic [31:0] addr; logic w; logic d; int due;} exp_t;
   exp_t        sb[$];
   int          total = 0, bad = 0, cyc = 0;
   logic        mon_en = 1'b0;
   logic        m_active = 1'b0;
   logic [31:0] m_addr, m_start, m_stride;
   logic [7:0]  m_len, m_idx;
   logic [15:0] m_reps, m_pass;
   always @(posedge clk) cyc <= cyc + 1;
   always @(negedge clk) begin
      if (mon_en) begin
         exp_t e;
         total++;
         if (sb.size() > 0 && sb[0].due == cyc) begin
            e = sb.pop_front();
            if ({ctr_valid, ctr_val, wrap, done} !== {1'b1, e.addr, e.w, e.d}) begin
               bad++;
               $display("FAIL sb_issue cyc=%0d got v=%b a=%h w=%b d=%b want v=1 a=%h w=%b d=%b",
                        cyc, ctr_valid, ctr_val, wrap, done, e.addr, e.w, e.d);
            end
         end else if ({ctr_valid, wrap, done} !== 3'b000) begin
            bad++;
            $display("FAIL sb_bubble cyc=%0d got v=%b w=%b d=%b want 000", cyc, ctr_valid, wrap, done);
         end
      end
   end
   task automatic tick(input logic en, input logic ld, input logic [31:0] sv = 0,
                       input logic [7:0] ln = 0, input logic [31:0] st = 0, input logic [15:0] rp = 0);
      exp_t e;
      @(posedge clk); #1;
      enable = en; load = ld; start_val = sv; length = ln; stride = st; reps = rp;
      if (ld) begin
         m_active = 1'b1; m_start = sv; m_addr = sv; m_stride = st;
         m_len = (ln == 0) ? 8'd14 : ln; m_reps = rp; m_idx = 0; m_pass = 0;
      end else if (m_active && en) begin
         e.addr = m_addr; e.w = (m_idx == m_len - 8'd1);
         e.d = e.w && m_reps != 0 && m_pass == m_reps - 16'd1; e.due = cyc + L;
         sb.push_back(e);
         if (e.w) begin
            m_addr = m_start; m_idx = 0; m_pass = m_pass + 16'd1;
            if (e.d) m_active = 1'b0;
         end else begin
            m_addr = m_addr + m_stride; m_idx = m_idx + 8'd1;
         end
      end
   endtask
   task automatic test_reset;
      rst = 1'b1;
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      total++;
      if ({ctr_val, ctr_valid, wrap, done, busy} !== 36'd0) begin
         bad++;
         $display("FAIL reset_outputs got a=%h v=%b w=%b d=%b b=%b want all 0", ctr_val, ctr_valid, wrap, done, busy);
      end
      mon_en = 1'b1;
   endtask
   task automatic test_basic;
      int t;
      tick(1, 1, 100, 0, 1, 1);
      t = cyc;
      for (int i = 0; i < 18; i++) begin
         tick(1, 0);
         if (cyc == t + 16 || cyc == t + 17) begin
            @(negedge clk);
            total++;
            if (busy !== (cyc == t + 16)) begin
               bad++;
               $display("FAIL basic_busy cyc=t+%0d got %b want %b", cyc - t, busy, cyc == t + 16);
            end
         end
      end
      total++;
      if (sb.size() != 0) begin bad++; $display("FAIL basic_drain got %0d pending want 0", sb.size()); end
   endtask
   task automatic test_stride;
      tick(1, 1, 0, 3, 4, 2);
      repeat (10) tick(1, 0);
      total++;
      if (sb.size() != 0 || busy !== 1'b0) begin
         bad++; $display("FAIL stride_drain got pending=%0d busy=%b want 0 0", sb.size(), busy);
      end
   endtask
   task automatic test_stall;
      tick(0, 1, 0, 3, 4, 2);
      for (int i = 0; i < 20; i++) tick((i % 3) == 0, 0);
      repeat (4) tick(0, 0);
      total++;
      if (sb.size() != 0 || m_active) begin
         bad++; $display("FAIL stall_drain got pending=%0d active=%b want 0 0", sb.size(), m_active);
      end
   endtask
   task automatic test_infinite_reload;
      tick(1, 1, 10, 2, 1, 0);
      repeat (7) tick(1, 0);
      tick(1, 1, 50, 2, 1, 0);
      repeat (5) tick(1, 0);
      repeat (4) tick(0, 0);
      total++;
      if (sb.size() != 0 || busy !== 1'b1) begin
         bad++; $display("FAIL infinite_state got pending=%0d busy=%b want 0 1", sb.size(), busy);
      end
   endtask
   task automatic test_overflow;
      tick(1, 1, 32'hFFFF_FFFE, 4, 1, 1);
      repeat (8) tick(1, 0);
      total++;
      if (sb.size() != 0 || busy !== 1'b0) begin
         bad++; $display("FAIL overflow_drain got pending=%0d busy=%b want 0 0", sb.size(), busy);
      end
   endtask
   task automatic test_reset_mid;
      tick(1, 1, 100, 0, 1, 1);
      repeat (6) tick(1, 0);
      @(posedge clk); #1;
      rst = 1'b1; enable = 1'b0; load = 1'b0; mon_en = 1'b0;
      sb.delete(); m_active = 1'b0;
      @(posedge clk); #1 rst = 1'b0;
      @(negedge clk);
      total++;
      if ({ctr_val, ctr_valid, wrap, done, busy} !== 36'd0) begin
         bad++;
         $display("FAIL reset_mid got a=%h v=%b w=%b d=%b b=%b want all 0", ctr_val, ctr_valid, wrap, done, busy);
      end
      mon_en = 1'b1;
      repeat (6) tick(1, 0);
      @(negedge clk);
      total++;
      if (busy !== 1'b0) begin bad++; $display("FAIL reset_mid_busy got %b want 0", busy); end
   endtask
   initial begin
      test_reset;
      test_basic;
      test_stride;
      test_stall;
      test_infinite_reload;
      test_overflow;
      test_reset_mid;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
